// File: rtl/sobel_pkg.sv
// Shared definitions for the frame pixel streamer.
// Holds the default frame geometry and pixel width, the controller state
// encoding, and the layout of one streamed beat (pixel plus sideband).
package sobel_pkg;

  localparam int ROWS   = 242;
  localparam int COLS   = 247;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } beat_t;

endpackage

// File: rtl/pix_fifo.sv
// Four-entry FIFO holding returned pixels with their sideband bits.
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears pointers and count)
//   push        - write push_data at the tail (caller never pushes when full)
//   push_data   - entry to write
//   pop         - remove the head entry (ignored when empty)
//   head        - current head entry
//   count       - number of stored entries, 0..4
module pix_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [2:0]   count
);

  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 3'd0);
  assign head   = mem[rd_ptr];

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 2'd1;
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Streams one ROWS x COLS frame out of a synchronous frame memory as a
// valid/ready pixel stream with start-of-frame, end-of-line and
// end-of-frame sideband.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   start               - one-cycle frame request, honoured only when idle
//   busy, done          - frame in progress / one-cycle completion pulse
//   mem_en, mem_addr    - frame-memory read request (row-major address)
//   mem_rdata           - read data, one cycle after the sampled request
//   m_valid, m_ready    - output beat handshake
//   m_data, m_sof, m_eol, m_eof - pixel and its sideband
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ISSUE | issuing reads while FIFO credit allows
// ST_DRAIN | all reads issued, waiting for the eof beat to handshake
// ST_FIN   | one cycle, done asserted
module frame_pixel_streamer #(
  parameter int ROWS   = sobel_pkg::ROWS,
  parameter int COLS   = sobel_pkg::COLS,
  parameter int PIX_W  = sobel_pkg::PIX_W,
  parameter int ADDR_W = sobel_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);
  import sobel_pkg::*;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FW = PIX_W + 3;

  state_e            state;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] addr;
  logic              row_last;
  logic              col_last;
  logic              last_issue;
  logic              issue;
  logic [2:0]        issue_sb;
  logic              rd_vld;
  logic [2:0]        rd_sb;
  logic              pop;
  logic [2:0]        fifo_count;
  logic [FW-1:0]     fifo_head;

  assign row_last   = (row == RW'(ROWS - 1));
  assign col_last   = (col == CW'(COLS - 1));
  assign last_issue = row_last && col_last;
  assign issue_sb   = {(row == '0) && (col == '0), col_last, last_issue};

  // Credit check uses only registered terms. At most one read is in flight
  // (single-cycle memory), so the FIFO peaks at 3 of its 4 entries.
  assign issue = (state == ST_ISSUE) && ((fifo_count + {2'b00, rd_vld}) <= 3'd2);

  assign mem_en   = issue;
  assign mem_addr = addr;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);

  assign m_valid = (fifo_count != 3'd0);
  assign pop     = m_valid && m_ready;
  assign {m_data, m_sof, m_eol, m_eof} = m_valid ? fifo_head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_ISSUE;
        ST_ISSUE: if (issue && last_issue) state <= ST_DRAIN;
        ST_DRAIN: if (pop && fifo_head[0]) state <= ST_FIN;
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (issue) begin
      if (last_issue) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else begin
        addr <= addr + 1'b1;
        if (col_last) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Sideband rides alongside the read so it meets its data at the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_sb  <= 3'b000;
    end else begin
      rd_vld <= issue;
      if (issue) rd_sb <= issue_sb;
    end
  end

  pix_fifo #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_vld),
    .push_data ({mem_rdata, rd_sb}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_frame_pixel_streamer.sv
module tb_frame_pixel_streamer;
  import sobel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [3:0]  start_v = 4'b0;
  logic [3:0]  busy_v, done_v, en_v, valid_v, sof_v, eol_v, eof_v;
  logic [15:0] addr_v [4];
  logic [7:0]  rdata_v [4];
  logic [7:0]  data_v [4];
  logic [1:0]  sel = 2'd0;

  int n_checks = 0;
  int n_fail = 0;
  beat_t exp_q[$];

  // Instance 0: full frame, 1: 24x25, 2: 3x4, 3: 1x1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RS = (g == 0) ? 242 : (g == 1) ? 24 : (g == 2) ? 3 : 1;
    localparam int CS = (g == 0) ? 247 : (g == 1) ? 25 : (g == 2) ? 4 : 1;
    frame_pixel_streamer #(.ROWS(RS), .COLS(CS), .PIX_W(8), .ADDR_W(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .mem_en    (en_v[g]),
      .mem_addr  (addr_v[g]),
      .mem_rdata (rdata_v[g]),
      .m_valid   (valid_v[g]),
      .m_ready   (rdy),
      .m_data    (data_v[g]),
      .m_sof     (sof_v[g]),
      .m_eol     (eol_v[g]),
      .m_eof     (eof_v[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (en_v[i]) rdata_v[i] <= addr_v[i][7:0];
  end

  logic        o_busy, o_done, o_en, o_valid;
  logic [15:0] o_addr;
  beat_t       got;
  assign o_busy  = busy_v[sel];
  assign o_done  = done_v[sel];
  assign o_en    = en_v[sel];
  assign o_valid = valid_v[sel];
  assign o_addr  = addr_v[sel];
  assign got     = {data_v[sel], sof_v[sel], eol_v[sel], eof_v[sel]};

  task automatic push_frame(input int rows, input int cols);
    beat_t b;
    for (int k = 0; k < rows * cols; k++) begin
      b.data = 8'(k);
      b.sof  = (k == 0);
      b.eol  = ((k % cols) == cols - 1);
      b.eof  = (k == rows * cols - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start(input int idx);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_v, done_v, en_v, valid_v, sof_v, eol_v, eof_v} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %h expected 0", {busy_v, done_v, en_v, valid_v, sof_v, eol_v, eof_v});
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (addr_v[i] !== 16'd0 || data_v[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_addr_data[%0d]: got %h/%h expected 0/0", i, addr_v[i], data_v[i]);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_v !== 4'd0 || en_v !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy %b en %b expected 0", busy_v, en_v);
    end
  endtask

  task automatic test_full_frame();
    int beats, bubbles;
    beat_t e;
    sel = 2'd0; rdy = 1'b1; beats = 0; bubbles = 0;
    push_frame(242, 247);
    pulse_start(0);
    n_checks++;
    if (o_en !== 1'b1 || o_addr !== 16'd0 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_latency_e0: en %b addr %0d valid %b busy %b expected 1 0 0 1", o_en, o_addr, o_valid, o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_latency_e1: valid %b expected 0", o_valid); end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency_e2: valid %b expected 1", o_valid); end
    for (int cyc = 0; cyc < 70000 && beats < 59774; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!o_valid) bubbles++;
      else begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL full_extra_beat: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL full_beat %0d: got %h expected %h", beats, got, e); end
        end
        beats++;
      end
    end
    n_checks++;
    if (beats != 59774 || bubbles != 0) begin
      n_fail++; $display("FAIL full_count: beats %0d bubbles %0d expected 59774 0", beats, bubbles);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_done: done %b valid %b expected 1 0", o_done, o_valid);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL full_idle: done %b busy %b expected 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_restart_ignored();
    int beats, dones;
    bit pulsed;
    beat_t e;
    sel = 2'd1; rdy = 1'b1; beats = 0; dones = 0; pulsed = 1'b0;
    push_frame(24, 25);
    pulse_start(1);
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start_v[1] = (beats == 100) && !pulsed;
      if (beats == 100) pulsed = 1'b1;
      if (o_done) dones++;
      if (o_valid && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL restart_extra_beat: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL restart_beat %0d: got %h expected %h", beats, got, e); end
        end
        beats++;
      end
    end
    start_v[1] = 1'b0;
    n_checks++;
    if (beats != 600 || dones != 1 || o_busy !== 1'b0 || !pulsed) begin
      n_fail++; $display("FAIL restart_once: beats %0d dones %0d busy %b expected 600 1 0", beats, dones, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int beats, dones;
    beat_t e;
    sel = 2'd1; rdy = 1'b1; beats = 0;
    push_frame(24, 25);
    pulse_start(1);
    for (int cyc = 0; cyc < 1000 && beats < 500; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (o_valid) begin
        e = exp_q.pop_front();
        beats++;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_v, done_v, en_v, valid_v, sof_v, eol_v, eof_v} !== 28'd0 || o_addr !== 16'd0 || got !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags %h addr %0d beat %h expected 0", {busy_v, done_v, en_v, valid_v, sof_v, eol_v, eof_v}, o_addr, got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: busy %b valid %b en %b expected 0", o_busy, o_valid, o_en);
    end
    push_frame(24, 25);
    pulse_start(1);
    n_checks++;
    if (o_en !== 1'b1 || o_addr !== 16'd0) begin
      n_fail++; $display("FAIL midreset_restart_addr: en %b addr %0d expected 1 0", o_en, o_addr);
    end
    beats = 0; dones = 0;
    for (int cyc = 0; cyc < 800 && dones == 0; cyc++) begin
      @(negedge clk);
      if (o_done) dones++;
      if (o_valid && rdy) begin
        n_checks++;
        e = exp_q.pop_front();
        if (got !== e) begin n_fail++; $display("FAIL midreset_beat %0d: got %h expected %h", beats, got, e); end
        beats++;
      end
    end
    n_checks++;
    if (beats != 600 || dones != 1) begin
      n_fail++; $display("FAIL midreset_count: beats %0d dones %0d expected 600 1", beats, dones);
    end
  endtask

  task automatic test_backpressure();
    int issued, beats, dones, waited;
    beat_t e;
    sel = 2'd1; rdy = 1'b0; issued = 0; beats = 0; dones = 0; waited = 0;
    push_frame(24, 25);
    pulse_start(1);
    while (!o_valid && waited < 10) begin
      if (o_en) issued++;
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!o_valid) begin n_fail++; $display("FAIL bp_first_valid: valid %b expected 1", o_valid); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (o_en) issued++;
      n_checks++;
      if (o_valid !== 1'b1 || got.data !== 8'd0 || got.sof !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold %0d: valid %b beat %h expected 1 with data 0 sof 1", cyc, o_valid, got);
      end
      @(negedge clk);
    end
    n_checks++;
    if (issued != 3 || o_en !== 1'b0) begin
      n_fail++; $display("FAIL bp_credit: issued %0d en %b expected 3 0", issued, o_en);
    end
    rdy = 1'b1;
    for (int cyc = 0; cyc < 800 && dones == 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (o_done) dones++;
      if (o_valid && rdy) begin
        n_checks++;
        e = exp_q.pop_front();
        if (got !== e) begin n_fail++; $display("FAIL bp_beat %0d: got %h expected %h", beats, got, e); end
        beats++;
      end
    end
    n_checks++;
    if (beats != 600 || dones != 1) begin
      n_fail++; $display("FAIL bp_count: beats %0d dones %0d expected 600 1", beats, dones);
    end
  endtask

  task automatic test_random_ready();
    int beats, dones;
    bit stalled;
    beat_t e, held;
    sel = 2'd2; rdy = 1'b0; beats = 0; dones = 0; stalled = 1'b0; held = '0;
    push_frame(3, 4);
    pulse_start(2);
    for (int cyc = 0; cyc < 500 && dones == 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (o_done) dones++;
      if (stalled) begin
        n_checks++;
        if (o_valid !== 1'b1 || got !== held) begin
          n_fail++; $display("FAIL rand_stall_hold: valid %b beat %h expected 1 %h", o_valid, got, held);
        end
      end
      rdy = 1'($urandom_range(0, 1));
      if (o_valid && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_beat: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL rand_beat %0d: got %h expected %h", beats, got, e); end
        end
        beats++;
      end
      stalled = o_valid && !rdy;
      held = got;
    end
    n_checks++;
    if (beats != 12 || dones != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_count: beats %0d dones %0d left %0d expected 12 1 0", beats, dones, exp_q.size());
    end
  endtask

  task automatic test_single_pixel();
    int beat_cyc, done_cyc;
    beat_t e;
    sel = 2'd3; rdy = 1'b1; beat_cyc = -1; done_cyc = -1;
    push_frame(1, 1);
    pulse_start(3);
    for (int cyc = 0; cyc < 20 && done_cyc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (o_done) done_cyc = cyc;
      if (o_valid && rdy) begin
        n_checks++;
        e = exp_q.pop_front();
        if (got !== e || {got.sof, got.eol, got.eof} !== 3'b111) begin
          n_fail++; $display("FAIL single_beat: got %h expected %h with sof eol eof set", got, e);
        end
        beat_cyc = cyc;
      end
    end
    n_checks++;
    if (beat_cyc < 0 || done_cyc != beat_cyc + 1) begin
      n_fail++; $display("FAIL single_done: beat cycle %0d done cycle %0d expected done one cycle after beat", beat_cyc, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_restart_ignored();
    test_reset_mid();
    test_backpressure();
    test_random_ready();
    test_single_pixel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
